// File: rtl/fp_mul_seq_rne.sv
// Sequential IEEE-754 multiplier: radix-2 shift-add mantissa core, one
// normalise/round cycle, round-to-nearest-even, subnormals flushed to zero.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// MUL   | shift-add, one multiplier bit per cycle (MAN_W+1 cycles)
// NORM  | normalise, round, range check
// DONE  | result held; out_valid rises one cycle after entry
module fp_mul_seq_rne #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 invalid
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int P     = MAN_W + 1;
    localparam int EW    = EXP_W + 2;
    localparam int CNT_W = $clog2(MAN_W + 1);

    localparam logic [EW-1:0]    BIAS_E  = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0]    EMAX_E  = EW'((1 << EXP_W) - 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(MAN_W);
    localparam logic [W-1:0]     QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [P-1:0]       mcand_q, mcand_d;
    logic [P-1:0]       mplier_q, mplier_d;
    logic [2*P-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [EW-1:0]      exp_q, exp_d;
    logic               sign_q, sign_d;
    logic [W-1:0]       result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               invalid_q, invalid_d;
    logic               out_valid_q, out_valid_d;

    // Operand field split and classification
    logic               a_sign, b_sign, p_sign;
    logic [EXP_W-1:0]   a_exp, b_exp;
    logic [MAN_W-1:0]   a_frac, b_frac;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, any_special;

    assign a_sign = a[W-1];
    assign b_sign = b[W-1];
    assign p_sign = a_sign ^ b_sign;
    assign a_exp  = a[MAN_W +: EXP_W];
    assign b_exp  = b[MAN_W +: EXP_W];
    assign a_frac = a[MAN_W-1:0];
    assign b_frac = b[MAN_W-1:0];
    assign a_nan  = (&a_exp) && (|a_frac);
    assign b_nan  = (&b_exp) && (|b_frac);
    assign a_inf  = (&a_exp) && !(|a_frac);
    assign b_inf  = (&b_exp) && !(|b_frac);
    assign a_zero = !(|a_exp);
    assign b_zero = !(|b_exp);
    assign any_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    // Special-operand result, NaN first, then inf*zero, inf, zero
    logic [W-1:0] spec_res;
    logic         spec_inv;
    always_comb begin
        spec_res = '0;
        spec_inv = 1'b0;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (a_inf || b_inf) begin
            spec_res = {p_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            spec_res = {p_sign, {(EXP_W+MAN_W){1'b0}}};
        end
    end

    // One shift-add step: add multiplicand into the upper half, shift right
    logic [P:0] mul_sum;
    always_comb begin
        mul_sum = {1'b0, acc_q[2*P-1:P]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    end

    // Normalise, round to nearest even, and range-check the finished product
    logic               nrm_top, nrm_guard, nrm_sticky, nrm_rnd;
    logic [P-1:0]       nrm_mant;
    logic [P:0]         nrm_mant_r;
    logic [EW-1:0]      nrm_exp;
    logic [MAN_W-1:0]   nrm_frac;
    logic [W-1:0]       nrm_res;
    logic               nrm_ovf, nrm_unf;
    always_comb begin
        nrm_top = acc_q[2*MAN_W+1];
        if (nrm_top) begin
            nrm_mant   = acc_q[2*MAN_W+1:MAN_W+1];
            nrm_guard  = acc_q[MAN_W];
            nrm_sticky = |acc_q[MAN_W-1:0];
            nrm_exp    = exp_q + EW'(1);
        end else begin
            nrm_mant   = acc_q[2*MAN_W:MAN_W];
            nrm_guard  = acc_q[MAN_W-1];
            nrm_sticky = |acc_q[MAN_W-2:0];
            nrm_exp    = exp_q;
        end
        nrm_rnd    = nrm_guard && (nrm_sticky || nrm_mant[0]);
        nrm_mant_r = {1'b0, nrm_mant} + (P+1)'(nrm_rnd);
        // A carry out of rounding leaves 1.000..0, so the fraction is all zeros
        if (nrm_mant_r[P]) begin
            nrm_exp  = nrm_exp + EW'(1);
            nrm_frac = '0;
        end else begin
            nrm_frac = nrm_mant_r[MAN_W-1:0];
        end
        nrm_ovf = 1'b0;
        nrm_unf = 1'b0;
        if (!nrm_exp[EW-1] && (nrm_exp >= EMAX_E)) begin
            nrm_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            nrm_ovf = 1'b1;
        end else if (nrm_exp[EW-1] || (nrm_exp == '0)) begin
            nrm_res = {sign_q, {(EXP_W+MAN_W){1'b0}}};
            nrm_unf = 1'b1;
        end else begin
            nrm_res = {sign_q, nrm_exp[EXP_W-1:0], nrm_frac};
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        invalid_d   = invalid_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    invalid_d   = 1'b0;
                    if (any_special) begin
                        result_d  = spec_res;
                        invalid_d = spec_inv;
                        state_d   = S_DONE;
                    end else begin
                        mcand_d  = {1'b1, a_frac};
                        mplier_d = {1'b1, b_frac};
                        acc_d    = '0;
                        cnt_d    = '0;
                        sign_d   = p_sign;
                        exp_d    = {2'b00, a_exp} + {2'b00, b_exp} - BIAS_E;
                        state_d  = S_MUL;
                    end
                end
            end
            S_MUL: begin
                acc_d    = {mul_sum, acc_q[P-1:1]};
                mplier_d = mplier_q >> 1;
                if (cnt_q == CNT_END) begin
                    cnt_d   = '0;
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_NORM: begin
                result_d    = nrm_res;
                overflow_d  = nrm_ovf;
                underflow_d = nrm_unf;
                state_d     = S_DONE;
            end
            S_DONE: begin
                out_valid_d = !(out_valid_q && out_ready);
                if (out_valid_q && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            invalid_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            invalid_q   <= invalid_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign invalid   = invalid_q;

endmodule

// File: tb/tb_fp_mul_seq_rne.sv
// Bench for fp_mul_seq_rne: binary32 and binary16 instances checked against
// an exact-arithmetic reference model plus hand-computed literals.
module tb_fp_mul_seq_rne;

    typedef struct {
        logic [63:0] res;
        logic        ovf;
        logic        unf;
        logic        inv;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv32, ir32, ov32, or32, ovf32, unf32, inv32;
    logic [31:0] a32, b32, r32;
    logic        iv16, ir16, ov16, or16, ovf16, unf16, inv16;
    logic [15:0] a16, b16, r16;

    int errors = 0;
    int checks = 0;
    exp_t q32[$];
    exp_t q16[$];

    fp_mul_seq_rne #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .out_valid(ov32), .out_ready(or32), .result(r32),
        .overflow(ovf32), .underflow(unf32), .invalid(inv32));

    fp_mul_seq_rne #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(or16), .result(r16),
        .overflow(ovf16), .underflow(unf16), .invalid(inv16));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact integer product, explicit RNE on the discarded remainder
    function automatic void fp_model(input logic [63:0] a, input logic [63:0] b,
                                     input int ew, input int mw,
                                     output logic [63:0] res, output logic ovf,
                                     output logic unf, output logic inv);
        longint unsigned emax, mask, ea, eb, fa, fb, sgn, qnan;
        logic [127:0] p, q, rem, half;
        int bias, k, sh, e;
        bit found;
        emax = (64'd1 << ew) - 1;
        mask = (64'd1 << mw) - 1;
        bias = (1 << (ew - 1)) - 1;
        ea = (a >> mw) & emax;
        eb = (b >> mw) & emax;
        fa = a & mask;
        fb = b & mask;
        sgn = ((a >> (ew + mw)) ^ (b >> (ew + mw))) & 1;
        qnan = (emax << mw) | (64'd1 << (mw - 1));
        ovf = 0; unf = 0; inv = 0;
        if ((ea == emax && fa != 0) || (eb == emax && fb != 0)) begin
            res = qnan;
        end else if ((ea == emax && eb == 0) || (ea == 0 && eb == emax)) begin
            res = qnan; inv = 1;
        end else if (ea == emax || eb == emax) begin
            res = (sgn << (ew + mw)) | (emax << mw);
        end else if (ea == 0 || eb == 0) begin
            res = sgn << (ew + mw);
        end else begin
            p = 128'((64'd1 << mw) | fa) * 128'((64'd1 << mw) | fb);
            k = 0; found = 0;
            for (int i = 127; i >= 0; i--) begin
                if (!found && p[i]) begin k = i; found = 1; end
            end
            e = k - 2 * mw + int'(ea) + int'(eb) - 2 * bias;
            sh = k - mw;
            q = p >> sh;
            rem = p - (q << sh);
            half = 128'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if ((q >> (mw + 1)) != 0) begin q = q >> 1; e = e + 1; end
            e = e + bias;
            if (e >= int'(emax)) begin
                res = (sgn << (ew + mw)) | (emax << mw); ovf = 1;
            end else if (e <= 0) begin
                res = sgn << (ew + mw); unf = 1;
            end else begin
                res = (sgn << (ew + mw)) | (64'(e) << mw) | (q[63:0] & mask);
            end
        end
    endfunction

    // Output checker: every cycle out_valid is high, compare against the queue head
    always @(negedge clk) begin
        if (!rst) begin
            if (ov32) begin
                if (q32.size() == 0) begin
                    check("out32_spurious", 64'(ov32), 64'd0);
                end else begin
                    check("out32", {29'd0, r32, ovf32, unf32, inv32},
                          {29'd0, q32[0].res[31:0], q32[0].ovf, q32[0].unf, q32[0].inv});
                    if (or32) void'(q32.pop_front());
                end
            end
            if (ov16) begin
                if (q16.size() == 0) begin
                    check("out16_spurious", 64'(ov16), 64'd0);
                end else begin
                    check("out16", {45'd0, r16, ovf16, unf16, inv16},
                          {45'd0, q16[0].res[15:0], q16[0].ovf, q16[0].unf, q16[0].inv});
                    if (or16) void'(q16.pop_front());
                end
            end
        end
    end

    // Issue one binary32 operation; returns with out_valid high (after the
    // handshake edge if out_ready is high)
    task automatic issue32(input string name, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] lit, input logic [2:0] lit_flags,
                           input int lat, input bit junk);
        exp_t e;
        int n;
        fp_model({32'd0, av}, {32'd0, bv}, 8, 23, e.res, e.ovf, e.unf, e.inv);
        check({name, "_model"}, {29'd0, e.res[31:0], e.ovf, e.unf, e.inv}, {29'd0, lit, lit_flags});
        n = 0;
        while (!ir32 && n < 100) begin @(posedge clk); #1; n++; end
        check({name, "_ready_timeout"}, 64'(ir32), 64'd1);
        a32 = av; b32 = bv; iv32 = 1'b1;
        @(posedge clk);
        q32.push_back(e);
        #1 iv32 = 1'b0;
        a32 = ~av; b32 = ~bv;
        n = 0;
        while (!ov32 && n < 100) begin
            if (ir32) check({name, "_in_ready_busy"}, 64'(ir32), 64'd0);
            if (junk && n == 3) begin iv32 = 1'b1; a32 = 32'h7FC0_0000; b32 = 32'h0; end
            if (junk && n == 6) iv32 = 1'b0;
            @(posedge clk); #1; n++;
        end
        check({name, "_latency"}, 64'(n), 64'(lat));
        check({name, "_lit"}, {61'd0, ovf32, unf32, inv32} | (64'(r32) << 3),
              {61'd0, lit_flags} | (64'(lit) << 3));
        if (or32) begin @(posedge clk); #1; end
    endtask

    task automatic issue16(input string name, input logic [15:0] av, input logic [15:0] bv,
                           input logic [15:0] lit, input logic [2:0] lit_flags, input int lat);
        exp_t e;
        int n;
        fp_model({48'd0, av}, {48'd0, bv}, 5, 10, e.res, e.ovf, e.unf, e.inv);
        check({name, "_model"}, {45'd0, e.res[15:0], e.ovf, e.unf, e.inv}, {45'd0, lit, lit_flags});
        n = 0;
        while (!ir16 && n < 100) begin @(posedge clk); #1; n++; end
        check({name, "_ready_timeout"}, 64'(ir16), 64'd1);
        a16 = av; b16 = bv; iv16 = 1'b1;
        @(posedge clk);
        q16.push_back(e);
        #1 iv16 = 1'b0;
        n = 0;
        while (!ov16 && n < 100) begin @(posedge clk); #1; n++; end
        check({name, "_latency"}, 64'(n), 64'(lat));
        check({name, "_lit"}, {45'd0, r16, ovf16, unf16, inv16}, {45'd0, lit, lit_flags});
        if (or16) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst = 1'b1;
        iv32 = 1'b0; a32 = '0; b32 = '0; or32 = 1'b1;
        iv16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset32", {57'd0, ir32, ov32, ovf32, unf32, inv32, 2'd0} | (64'(r32) << 8), 64'h40);
        check("reset16", {57'd0, ir16, ov16, ovf16, unf16, inv16, 2'd0} | (64'(r16) << 8), 64'h40);

        // flags order: {overflow, underflow, invalid}
        issue32("basic",      32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 26, 1'b1);
        issue32("tie_up",     32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 3'b000, 26, 1'b0);
        issue32("tie_even",   32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, 3'b000, 26, 1'b0);
        issue32("below_half", 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 3'b000, 26, 1'b0);
        issue32("neg",        32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000, 3'b000, 26, 1'b0);
        issue32("ovf",        32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 3'b100, 26, 1'b0);
        issue32("unf",        32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 3'b010, 26, 1'b0);
        issue32("inf_zero",   32'h7F80_0000, 32'h8000_0000, 32'h7FC0_0000, 3'b001, 1, 1'b0);
        issue32("nan",        32'h7FC0_1234, 32'h3F80_0000, 32'h7FC0_0000, 3'b000, 1, 1'b0);
        issue32("neg_inf",    32'hBF80_0000, 32'h7F80_0000, 32'hFF80_0000, 3'b000, 1, 1'b0);
        issue32("subnorm",    32'h0000_0001, 32'hBF80_0000, 32'h8000_0000, 3'b000, 1, 1'b0);

        // Backpressure: result held, in_ready low, then handshake and re-issue
        or32 = 1'b0;
        issue32("bp", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 26, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {30'd0, ov32, ir32, r32}, {30'd0, 1'b1, 1'b0, 32'h4040_0000});
        end
        or32 = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {62'd0, ov32, ir32}, {62'd0, 1'b0, 1'b1});
        issue32("bp_next", 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 3'b000, 26, 1'b0);

        // Reset while MUL counter is at 10
        a32 = 32'h3FC0_0000; b32 = 32'h4000_0000; iv32 = 1'b1;
        @(posedge clk);
        #1 iv32 = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_reset", {57'd0, ir32, ov32, ovf32, unf32, inv32, 2'd0} | (64'(r32) << 8), 64'h40);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (ov32) seen++; end
            check("abort_no_valid", 64'(seen), 64'd0);
        end

        issue16("h_basic", 16'h3E00, 16'h4000, 16'h4200, 3'b000, 13);
        issue16("h_ovf",   16'h7800, 16'h4800, 16'h7C00, 3'b100, 13);
        issue16("h_inv",   16'h0000, 16'hFC00, 16'h7E00, 3'b001, 1);

        repeat (5) @(posedge clk);
        check("queues_drained", 64'(q32.size() + q16.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_mul_seq_rne.md
# fp_mul_seq_rne

Parametrised sequential IEEE-754 floating-point multiplier with valid/ready handshakes, round-to-nearest-even and full special-operand handling. Next generation of the team's single-precision sequential FP multiplier; the same radix-2 shift-add core, now width-generic (binary16/32/64) and stream-friendly. Sits between operand-issue logic and the result writeback stage of the arithmetic datapath.

## Interface
- EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1
- MAN_W, 23, stored fraction width; W = 1+EXP_W+MAN_W
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands a/b valid
- in_ready  out  1  block can accept operands
- a  in  W  operand A, IEEE format {sign, exp, frac}
- b  in  W  operand B
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  W  rounded product
- overflow  out  1  finite product rounded beyond max normal
- underflow  out  1  nonzero product flushed to zero
- invalid  out  1  inf × zero

## Operation
- FSM: IDLE, MUL, NORM, DONE. in_ready = (state==IDLE).
- IDLE: on in_valid && in_ready, register a, b; classify operands. If special, go to DONE with the special result; else load the multiplicand {1,fracA} and multiplier {1,fracB}, clear the 2(MAN_W+1)-bit accumulator, counter=0, and go to MUL.
- Subnormal inputs (exp==0) are treated as signed zero (flush-to-zero).
- Specials, in priority order:
  - Any NaN input -> canonical qNaN {0, all-ones exp, 1, zeros}; invalid=0.
  - inf × zero -> canonical qNaN; invalid=1.
  - inf × finite -> signed inf.
  - zero × finite -> signed zero.
- Sign is always a_sign ^ b_sign except for canonical NaN.
- MUL: one multiplier bit per cycle, shift-add over MAN_W+1 cycles; counter wraps to 0 on exit; go to NORM.
- NORM, single cycle:
  - If product bit[2MAN_W+1] is set, shift right 1 and increment the exponent.
  - Take guard bit, sticky = OR of the lower bits; round to nearest, ties to even.
  - A rounding carry out of the mantissa renormalises: shift again and exp+1.
  - Exponent is computed signed in EXP_W+2 bits: e = ea + eb - BIAS + adjustments.
  - e >= 2^EXP_W-1 -> signed inf, overflow=1.
  - e <= 0 -> signed zero, underflow=1.
  - Go to DONE.
- DONE: out_valid=1; result and flags held stable until out_ready. On out_valid && out_ready go to IDLE and drop out_valid.
- Flags are meaningful only while out_valid=1; they are cleared on the IDLE->MUL/DONE transition.

## Timing
- Reset values: in_ready=1 (state IDLE) the cycle after rst; out_valid=0, result=0, overflow=0, underflow=0, invalid=0; counter=0.
- rst mid-operation aborts the operation; no result is produced.
- Normal operands accepted at edge T: out_valid rises at edge T+MAN_W+3 (26 cycles for binary32, 13 for binary16).
- Special operands: out_valid at edge T+1.
- Back-to-back issue: the next accept happens no earlier than the edge after the out_valid&&out_ready handshake (in_ready rises the cycle after).
- Inputs are sampled only on the accept edge; a/b changing during MUL has no effect.
- in_valid asserted while busy is ignored (not queued).

## Test plan
- 0x3FC00000 × 0x40000000 -> result 0x40400000, flags 0, out_valid exactly 26 cycles after accept, in_ready low throughout.
- RNE ties: 0x3F800001 × 0x3FC00000 -> 0x3FC00002 (round up to even); 0x3F800003 × 0x3FC00000 -> 0x3FC00004 (stay even); 0x3F800001 × 0x3F800001 -> 0x3F800002 (below half).
- 0x7F000000 × 0x40000000 -> 0x7F800000, overflow=1. 0x00800000 × 0x3F000000 -> 0x00000000, underflow=1.
- 0x7F800000 × 0x80000000 -> 0x7FC00000, invalid=1, out_valid 1 cycle after accept. 0x7FC01234 × 0x3F800000 -> 0x7FC00000, invalid=0.
- Backpressure/reset: hold out_ready=0 for 10 cycles -> result/flags stable and in_ready=0; then pulse out_ready -> next operands accepted. Assert rst at MUL counter=10 -> all outputs at reset values next cycle, no out_valid.
- EXP_W=5, MAN_W=10: 0x3E00 × 0x4000 -> 0x4200 with latency 13; 0x7800 × 0x4800 -> 0x7C00, overflow=1.
